// File: rtl/wiper_step_controller.sv
// Digital front end of a stepped potentiometer: X9C-style increment interface,
// saturating wiper code, break-before-make one-hot tap drive. Optional WIPER_STORE_EN adds store/recall.
`timescale 1ns/1ps
module wiper_step_controller #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int BBM_CYCLES  = 4,
    parameter int RESET_CODE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  inc_n,
    input  logic                  up,
    input  logic                  recall,
    output logic [WIDTH-1:0]      wiper,
    output logic [2**WIDTH-1:0]   tap_sel,
    output logic                  sw_en,
    output logic                  busy,
    output logic                  at_min,
    output logic                  at_max
);

    localparam int TAPS = 2**WIDTH;
    localparam int CW   = $clog2(BBM_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(BBM_CYCLES - 1);
    localparam logic [WIDTH-1:0] CODE_MAX = '1;
    localparam logic [WIDTH-1:0] CODE_RST = WIDTH'(RESET_CODE);
    localparam logic [TAPS-1:0]  TAP_ONE  = {{(TAPS-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BREAK = 2'd1;
    localparam logic [1:0] S_MAKE  = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] inc_sr;
    logic [SYNC_STAGES-1:0] up_sr;
    logic                   cs_s;
    logic                   inc_s;
    logic                   up_s;
    logic                   inc_hist;
    logic                   step_evt;
    logic                   step_up;

    logic                   recall_hit;
    logic [WIDTH-1:0]       recall_code;

    logic [WIDTH-1:0]       target;
    logic [WIDTH-1:0]       target_nx;

    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic [WIDTH-1:0]       wiper_nx;

    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign inc_s = inc_sr[SYNC_STAGES-1];
    assign up_s  = up_sr[SYNC_STAGES-1];

    // Pad synchronisers; the step event is registered so direction is captured alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sr    <= '1;
            inc_sr   <= '1;
            up_sr    <= '0;
            inc_hist <= 1'b1;
            step_evt <= 1'b0;
            step_up  <= 1'b0;
        end else begin
            cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            inc_sr   <= {inc_sr[SYNC_STAGES-2:0], inc_n};
            up_sr    <= {up_sr[SYNC_STAGES-2:0], up};
            inc_hist <= inc_s;
            step_evt <= inc_hist & ~inc_s & ~cs_s;
            step_up  <= up_s;
        end
    end

`ifdef WIPER_STORE_EN
    logic [SYNC_STAGES-1:0] rc_sr;
    logic                   rc_s;
    logic                   rc_hist;
    logic                   cs_hist;
    logic                   recall_evt;
    logic [WIDTH-1:0]       stored;

    assign rc_s        = rc_sr[SYNC_STAGES-1];
    assign recall_hit  = recall_evt;
    assign recall_code = stored;

    // Deselecting the chip with inc_n high commits the current target to the store.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_sr      <= '0;
            rc_hist    <= 1'b0;
            cs_hist    <= 1'b1;
            recall_evt <= 1'b0;
            stored     <= CODE_RST;
        end else begin
            rc_sr      <= {rc_sr[SYNC_STAGES-2:0], recall};
            rc_hist    <= rc_s;
            cs_hist    <= cs_s;
            recall_evt <= rc_s & ~rc_hist;
            if (cs_s && !cs_hist && inc_s) begin
                stored <= target;
            end
        end
    end
`else
    logic unused_recall;
    assign unused_recall = recall;
    assign recall_hit    = 1'b0;
    assign recall_code   = CODE_RST;
`endif

    always_comb begin
        target_nx = target;
        if (recall_hit) begin
            target_nx = recall_code;
        end else if (step_evt) begin
            if (step_up && target != CODE_MAX) begin
                target_nx = target + WIDTH'(1);
            end else if (!step_up && target != '0) begin
                target_nx = target - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target <= CODE_RST;
        end else begin
            target <= target_nx;
        end
    end

    // The wiper takes its target snapshot on entry to MAKE; later steps wait for the next sequence.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wiper_nx = wiper;
        case (state)
            S_IDLE: begin
                if (target != wiper) begin
                    state_nx = S_BREAK;
                    cnt_nx   = '0;
                end
            end
            S_BREAK: begin
                if (cnt == CNT_LAST) begin
                    state_nx = S_MAKE;
                    wiper_nx = target;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_MAKE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_BREAK;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_BREAK;
            cnt     <= '0;
            wiper   <= CODE_RST;
            sw_en   <= 1'b0;
            busy    <= 1'b1;
            tap_sel <= '0;
            at_min  <= (CODE_RST == '0);
            at_max  <= (CODE_RST == CODE_MAX);
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            wiper   <= wiper_nx;
            sw_en   <= (state_nx == S_IDLE);
            busy    <= (state_nx != S_IDLE);
            tap_sel <= (state_nx == S_IDLE) ? (TAP_ONE << wiper_nx) : '0;
            at_min  <= (wiper_nx == '0);
            at_max  <= (wiper_nx == CODE_MAX);
        end
    end

endmodule

// File: tb/tb_wiper_step_controller.sv
// Directed self-checking bench for wiper_step_controller (default parameters).
// Recall expectation follows WIPER_STORE_EN.
`timescale 1ns/1ps
module tb_wiper_step_controller;

    logic        clk;
    logic        rst;
    logic        cs_n;
    logic        inc_n;
    logic        up;
    logic        recall;
    logic [4:0]  wiper;
    logic [31:0] tap_sel;
    logic        sw_en;
    logic        busy;
    logic        at_min;
    logic        at_max;

    int checkCount = 0;
    int errorCount = 0;

    int          seqCount   = 0;
    int          tapChanges = 0;
    logic        busyPrev   = 1'b1;
    logic [31:0] tapPrev    = '0;

    wiper_step_controller dut (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .inc_n   (inc_n),
        .up      (up),
        .recall  (recall),
        .wiper   (wiper),
        .tap_sel (tap_sel),
        .sw_en   (sw_en),
        .busy    (busy),
        .at_min  (at_min),
        .at_max  (at_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts break-before-make sequences and tap-bus changes.
    always @(negedge clk) begin
        if (busy && !busyPrev) seqCount = seqCount + 1;
        if (tap_sel !== tapPrev) tapChanges = tapChanges + 1;
        busyPrev = busy;
        tapPrev  = tap_sel;
    end

    function automatic logic [31:0] onehot(input int k);
        logic [31:0] one;
        one = 32'd1;
        return one << k;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic dir, input int pulses, input int spacing);
        cs_n = cs;
        up   = dir;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < pulses; i++) begin
            inc_n = 1'b0;
            @(posedge clk);
            #1 inc_n = 1'b1;
            repeat (spacing - 1) @(posedge clk);
            #1;
        end
    endtask

    // Call right after rst is released following a single reset edge.
    task automatic checkResetRelease(input string tag);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput({tag, "_open_sw_en"}, sw_en, 1'b0);
            checkOutput({tag, "_open_tap"}, tap_sel, 32'd0);
            checkOutput({tag, "_open_busy"}, busy, 1'b1);
        end
        @(negedge clk);
        checkOutput({tag, "_sw_en"}, sw_en, 1'b1);
        checkOutput({tag, "_wiper"}, wiper, 32'd16);
        checkOutput({tag, "_tap"}, tap_sel, onehot(16));
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_at_min"}, at_min, 1'b0);
        checkOutput({tag, "_at_max"}, at_max, 1'b0);
    endtask

    task automatic resetDut(input string tag);
        rst    = 1'b1;
        cs_n   = 1'b1;
        inc_n  = 1'b1;
        up     = 1'b0;
        recall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_in_reset_busy"}, busy, 1'b1);
        checkOutput({tag, "_in_reset_tap"}, tap_sel, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        checkResetRelease(tag);
    endtask

    initial begin
        int s0;
        int t0;
        rst    = 1'b1;
        cs_n   = 1'b1;
        inc_n  = 1'b1;
        up     = 1'b0;
        recall = 1'b0;

        $display("[TB] reset release");
        resetDut("rst1");

        $display("[TB] single up step with latency");
        cs_n = 1'b0;
        up   = 1'b1;
        repeat (4) @(posedge clk);
        #1 inc_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1 if (c == 1) inc_n = 1'b1;
            @(negedge clk);
            if (c == 4) checkOutput("step_c4_sw_en", sw_en, 1'b1);
            if (c == 5) begin
                checkOutput("step_c5_sw_en", sw_en, 1'b0);
                checkOutput("step_c5_tap", tap_sel, 32'd0);
                checkOutput("step_c5_busy", busy, 1'b1);
            end
            if (c == 8) checkOutput("step_c8_wiper", wiper, 32'd16);
            if (c == 9) begin
                checkOutput("step_c9_wiper", wiper, 32'd17);
                checkOutput("step_c9_tap", tap_sel, 32'd0);
            end
            if (c == 10) begin
                checkOutput("step_c10_tap", tap_sel, onehot(17));
                checkOutput("step_c10_sw_en", sw_en, 1'b1);
                checkOutput("step_c10_busy", busy, 1'b0);
            end
        end

        $display("[TB] 20 fast up pulses");
        s0 = seqCount;
        applyStimulus(1'b0, 1'b1, 20, 3);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("burst_wiper", wiper, 32'd31);
        checkOutput("burst_at_max", at_max, 1'b1);
        checkOutput("burst_at_min", at_min, 1'b0);
        checkOutput("burst_tap", tap_sel, onehot(31));
        checkOutput("burst_busy", busy, 1'b0);
        checkOutput("burst_coalesced", (seqCount - s0) < 14, 1'b1);

        $display("[TB] up pulses at max");
        s0 = seqCount;
        t0 = tapChanges;
        applyStimulus(1'b0, 1'b1, 3, 3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("sat_sequences", seqCount - s0, 32'd0);
        checkOutput("sat_tap_changes", tapChanges - t0, 32'd0);
        checkOutput("sat_wiper", wiper, 32'd31);

        $display("[TB] pulses with chip deselected");
        resetDut("rst2");
        s0 = seqCount;
        applyStimulus(1'b1, 1'b1, 5, 3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("desel_wiper", wiper, 32'd16);
        checkOutput("desel_sequences", seqCount - s0, 32'd0);
        checkOutput("desel_busy", busy, 1'b0);

        $display("[TB] reset during break");
        cs_n = 1'b0;
        up   = 1'b1;
        repeat (4) @(posedge clk);
        #1 inc_n = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1 if (c == 1) inc_n = 1'b1;
        end
        @(negedge clk);
        checkOutput("midbreak_busy", busy, 1'b1);
        checkOutput("midbreak_wiper", wiper, 32'd16);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkResetRelease("rst3");

        $display("[TB] store and recall");
        applyStimulus(1'b0, 1'b1, 4, 12);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("store_wiper20", wiper, 32'd20);
        @(posedge clk);
        #1 cs_n = 1'b1;
        repeat (5) @(posedge clk);
        applyStimulus(1'b0, 1'b0, 2, 12);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("store_wiper18", wiper, 32'd18);
        checkOutput("store_tap18", tap_sel, onehot(18));
        @(posedge clk);
        #1 recall = 1'b1;
        repeat (2) @(posedge clk);
        #1 recall = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
`ifdef WIPER_STORE_EN
        checkOutput("recall_wiper", wiper, 32'd20);
        checkOutput("recall_tap", tap_sel, onehot(20));
`else
        checkOutput("recall_wiper", wiper, 32'd18);
        checkOutput("recall_tap", tap_sel, onehot(18));
`endif
        checkOutput("recall_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wiper_step_controller.md
Name: wiper_step_controller

Overview:
- Digital front end of the potentiometer. Accepts an X9C-style three-wire increment interface (cs_n, inc_n, up) plus a recall strobe, and maintains a saturating wiper code.
- Drives the one-hot tap-select bus of the analog resistor ladder.
- Every tap change uses a break-before-make sequence, so two ladder switches are never closed at the same time.

Parameters:
- WIDTH, 5, wiper code width; ladder has 2**WIDTH taps.
- SYNC_STAGES, 2, synchroniser flops on each pad input (min 2).
- BBM_CYCLES, 4, clocks all taps held open before a new tap closes (min 1).
- RESET_CODE, 16, wiper code loaded at reset (must be < 2**WIDTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  chip select, active low, asynchronous pad.
- inc_n  in  1  step strobe; a falling edge steps the wiper. Asynchronous pad.
- up  in  1  step direction (1 = toward max tap), asynchronous pad.
- recall  in  1  rising edge restores the stored code (see optional feature). Asynchronous pad.
- wiper  out  WIDTH  currently applied tap code.
- tap_sel  out  2**WIDTH  one-hot ladder switch enables; all zero while the ladder is open.
- sw_en  out  1  high when a tap is closed.
- busy  out  1  high while a break-before-make sequence is in progress.
- at_min  out  1  wiper == 0.
- at_max  out  1  wiper == 2**WIDTH-1.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.

Synchronisation and edge detection
- cs_n, inc_n, up and recall each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- A step event is a synced inc_n 1->0 transition while synced cs_n == 0. The event samples synced up in the same cycle.
- inc_n edges while cs_n is high are ignored.

Target register
- target (WIDTH bits) updates on the cycle after a step event.
- Step up: target+1. Step down: target-1.
- Saturating: up at max and down at 0 leave target unchanged. No sequence starts.

State machine: IDLE, BREAK, MAKE
- IDLE: sw_en=1, tap_sel=onehot(wiper), busy=0. If target != wiper, go to BREAK next cycle.
- BREAK: sw_en=0, tap_sel=0, busy=1. Counter counts BBM_CYCLES clocks, then go to MAKE.
- MAKE: wiper <= target snapshot, sw_en=0, busy=1. Go to IDLE next cycle; the new tap closes there.
- Step events during BREAK or MAKE still update target (coalesced). After returning to IDLE, a new sequence starts only if target != wiper. IDLE therefore lasts at least 1 cycle between sequences.
- at_min and at_max are derived from wiper (the applied code), not from target.

Reset
- wiper=target=RESET_CODE. FSM enters BREAK with counter cleared.
- sw_en=0, tap_sel=0, busy=1.
- After BBM_CYCLES clocks the FSM passes through MAKE, then reaches IDLE with tap RESET_CODE closed.
- rst asserted mid-sequence aborts the sequence and reapplies the above.
- Synchroniser flops reset to the idle pad levels: cs_n=1, inc_n=1, up=0, recall=0.

Latency (defaults)
- Pad inc_n fall is sampled at clock edge 0.
- Step event detected at cycle 3 (2 sync stages + 1 history flop); target updated at cycle 4.
- BREAK at cycles 5-8 (sw_en=0). MAKE at cycle 9, where wiper is updated.
- Cycle 10: IDLE, sw_en=1, new tap closed.

Optional Feature:
- Macro: WIPER_STORE_EN.
- Defined:
  - An internal stored register (WIDTH bits), reset to RESET_CODE.
  - A synced cs_n 0->1 transition while synced inc_n == 1 copies target into stored.
  - A synced recall 0->1 transition sets target = stored.
  - If recall and a step event occur in the same cycle, recall wins.
- Not defined:
  - No stored register. The recall input is ignored.
  - cs_n rising has no effect beyond ending step acceptance.

Test Plan:
- Reset release, defaults -> sw_en=0, tap_sel=0 for 5 cycles. Then sw_en=1, wiper=16, tap_sel=1<<16, at_min=at_max=0.
- cs_n=0, up=1, single inc_n pulse -> wiper=17 at cycle 9 after the pad edge. tap_sel=0 during cycles 5-9; tap_sel=1<<17 from cycle 10.
- cs_n=0, up=1, 20 inc_n pulses spaced 3 clocks apart -> pulses coalesce. wiper ends at 31 with at_max=1. Further up pulses cause no busy and no change in tap_sel.
- cs_n=1, 5 inc_n pulses -> wiper stays 16, busy stays 0.
- Reset asserted mid-BREAK while stepping 16->17 -> tap_sel=0 on the next cycle. Full reset sequence follows, ending with wiper=16.
- WIPER_STORE_EN defined: step to 20, raise cs_n with inc_n=1, then step down to 18. A recall pulse -> target=20 and one sequence runs, giving wiper=20. Without the macro, the same recall pulse leaves wiper at 18.
